spi_slave_rx_tx: RTL and testbench

SPI_SLAVE_RX_TX -- requirements
Module: spi_slave_rx_tx

---
 rtl/spi_slave_rx_tx.sv | 144 ++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-3 slave with synchronized SCLK/CS/MOSI, a single-word TX holding
// register that falls back to IDLE_TX, and a one-word RX register with a valid strobe.
module spi_slave_rx_tx #(
    parameter int unsigned       DATA_W  = 8,
    parameter logic [DATA_W-1:0] IDLE_TX = 8'hFF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              spi_clk_i,
    input  logic              spi_cs_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              tx_underrun_o
);

    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        StIdle,
        StActive
    } state_e;

    state_e              r_state;
    logic [2:0]          r_clk_sync;
    logic [2:0]          r_cs_sync;
    logic [1:0]          r_mosi_sync;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_underrun;
    logic [DATA_W-1:0]   r_hold;
    logic                r_hold_full;

    logic                w_clk_rise;
    logic                w_clk_fall;
    logic                w_cs_fall;
    logic                w_cs_rise;
    logic                w_mosi;
    logic                w_active;
    logic                w_tx_load;
    logic                w_tx_accept;

    // Stage [1] is the synchronized value; stage [2] only exists for edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_clk_sync  <= 3'b111;
            r_cs_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], spi_clk_i};
            r_cs_sync   <= {r_cs_sync[1:0], spi_cs_i};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi_i};
        end
    end

    assign w_clk_rise = r_clk_sync[1] & ~r_clk_sync[2];
    assign w_clk_fall = ~r_clk_sync[1] & r_clk_sync[2];
    assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_mosi     = r_mosi_sync[1];

    assign w_active    = (r_state == StActive);
    // A cs release wins over any SCLK edge seen in the same cycle.
    assign w_tx_load   = w_active & ~w_cs_rise & w_clk_fall & (r_bit_cnt == '0);
    assign w_tx_accept = tx_valid_i & ~r_hold_full;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_tx_accept) begin
            r_hold      <= tx_data_i;
            r_hold_full <= 1'b1;
        end else if (w_tx_load) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= StIdle;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_cs_fall) begin
                        r_state    <= StActive;
                        r_bit_cnt  <= '0;
                        r_rx_shift <= '0;
                    end
                end
                StActive: begin
                    if (w_cs_rise) begin
                        r_state    <= StIdle;
                        r_bit_cnt  <= '0;
                        r_rx_shift <= '0;
                    end else begin
                        if (w_tx_load) begin
                            r_tx_shift <= r_hold_full ? r_hold : IDLE_TX;
                            r_underrun <= ~r_hold_full;
                        end else if (w_clk_fall) begin
                            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        end
                        if (w_clk_rise) begin
                            r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi};
                            if (r_bit_cnt == LAST_BIT) begin
                                r_bit_cnt  <= '0;
                                r_rx_data  <= {r_rx_shift[DATA_W-2:0], w_mosi};
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign spi_miso_o    = w_active & r_tx_shift[DATA_W-1];
    assign spi_miso_oe_o = w_active;
    assign rx_data_o     = r_rx_data;
    assign rx_valid_o    = r_rx_valid;
    assign tx_ready_o    = ~r_hold_full;
    assign tx_underrun_o = r_underrun;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx: a mode-3 master model at sys_clk = 8x SCLK.
module tb_spi_slave_rx_tx;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       spi_clk = 1'b1;
    logic       spi_cs = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_underrun;

    int n_vec = 0;
    int n_err = 0;
    int rx_pulses = 0;
    int ur_pulses = 0;
    logic [7:0] rx_last = 8'h00;

    spi_slave_rx_tx #(
        .DATA_W (8),
        .IDLE_TX(8'hFF)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .spi_clk_i    (spi_clk),
        .spi_cs_i     (spi_cs),
        .spi_mosi_i   (spi_mosi),
        .spi_miso_o   (spi_miso),
        .spi_miso_oe_o(spi_miso_oe),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .tx_underrun_o(tx_underrun)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (!sys_rst && rx_valid) begin
            rx_pulses = rx_pulses + 1;
            rx_last   = rx_data;
        end
        if (!sys_rst && tx_underrun) ur_pulses = ur_pulses + 1;
    end

    task automatic tx_write(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge sys_clk);
        tx_valid = 1'b0;
    endtask

    // One SCLK period: fall/drive, 4 cycles, sample MISO and rise, 4 cycles.
    task automatic spi_bit(input logic mosi_b, output logic miso_b);
        spi_clk  = 1'b0;
        spi_mosi = mosi_b;
        repeat (4) @(negedge sys_clk);
        miso_b  = spi_miso;
        spi_clk = 1'b1;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic spi_word(input logic [7:0] m, output logic [7:0] s);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(m[i], b);
            s[i] = b;
        end
    endtask

    task automatic cs_begin();
        spi_cs = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic cs_end();
        spi_cs = 1'b1;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        n_vec++; if (tx_underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun got %b want 0", tx_underrun); end
        n_vec++; if (spi_miso !== 1'b0) begin n_err++; $display("FAIL reset_miso got %b want 0", spi_miso); end
        n_vec++; if (spi_miso_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe got %b want 0", spi_miso_oe); end
        n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_basic();
        logic [7:0] exp_miso = 8'hA5;
        logic [7:0] mosi_w = 8'h3C;
        logic       b;
        int         p0 = rx_pulses;
        int         u0 = ur_pulses;
        tx_write(8'hA5);
        n_vec++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_after_write got %b want 0", tx_ready); end
        cs_begin();
        n_vec++; if (spi_miso_oe !== 1'b1) begin n_err++; $display("FAIL basic_oe_active got %b want 1", spi_miso_oe); end
        for (int i = 7; i >= 0; i--) begin
            spi_bit(mosi_w[i], b);
            n_vec++; if (b !== exp_miso[i]) begin n_err++; $display("FAIL basic_miso_bit%0d got %b want %b", i, b, exp_miso[i]); end
        end
        n_vec++; if (rx_last !== 8'h3C) begin n_err++; $display("FAIL basic_rx_data got %h want 3c", rx_last); end
        n_vec++; if (rx_pulses - p0 != 1) begin n_err++; $display("FAIL basic_rx_pulses got %0d want 1", rx_pulses - p0); end
        n_vec++; if (ur_pulses - u0 != 0) begin n_err++; $display("FAIL basic_underrun got %0d want 0", ur_pulses - u0); end
        cs_end();
        n_vec++; if (spi_miso_oe !== 1'b0) begin n_err++; $display("FAIL basic_oe_idle got %b want 0", spi_miso_oe); end
        n_vec++; if (spi_miso !== 1'b0) begin n_err++; $display("FAIL basic_miso_idle got %b want 0", spi_miso); end
        n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_idle got %b want 1", tx_ready); end
    endtask

    task automatic test_underrun();
        logic [7:0] s;
        int         p0 = rx_pulses;
        int         u0 = ur_pulses;
        cs_begin();
        spi_word(8'h5A, s);
        cs_end();
        n_vec++; if (s !== 8'hFF) begin n_err++; $display("FAIL underrun_miso got %h want ff", s); end
        n_vec++; if (ur_pulses - u0 != 1) begin n_err++; $display("FAIL underrun_pulses got %0d want 1", ur_pulses - u0); end
        n_vec++; if (rx_last !== 8'h5A) begin n_err++; $display("FAIL underrun_rx_data got %h want 5a", rx_last); end
        n_vec++; if (rx_pulses - p0 != 1) begin n_err++; $display("FAIL underrun_rx_pulses got %0d want 1", rx_pulses - p0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1 = 8'hC3;
        logic [7:0] s1;
        logic [7:0] s2;
        logic       b;
        int         p0 = rx_pulses;
        int         u0 = ur_pulses;
        tx_write(8'h11);
        cs_begin();
        for (int i = 7; i >= 4; i--) begin
            spi_bit(m1[i], b);
            s1[i] = b;
        end
        n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_before_write got %b want 1", tx_ready); end
        tx_write(8'h22);
        n_vec++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_after_write got %b want 0", tx_ready); end
        for (int i = 3; i >= 0; i--) begin
            spi_bit(m1[i], b);
            s1[i] = b;
        end
        n_vec++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_before_load got %b want 0", tx_ready); end
        n_vec++; if (rx_last !== 8'hC3) begin n_err++; $display("FAIL b2b_rx_word1 got %h want c3", rx_last); end
        spi_word(8'h7E, s2);
        n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_load got %b want 1", tx_ready); end
        cs_end();
        n_vec++; if (s1 !== 8'h11) begin n_err++; $display("FAIL b2b_miso_word1 got %h want 11", s1); end
        n_vec++; if (s2 !== 8'h22) begin n_err++; $display("FAIL b2b_miso_word2 got %h want 22", s2); end
        n_vec++; if (rx_last !== 8'h7E) begin n_err++; $display("FAIL b2b_rx_word2 got %h want 7e", rx_last); end
        n_vec++; if (rx_pulses - p0 != 2) begin n_err++; $display("FAIL b2b_rx_pulses got %0d want 2", rx_pulses - p0); end
        n_vec++; if (ur_pulses - u0 != 0) begin n_err++; $display("FAIL b2b_underrun got %0d want 0", ur_pulses - u0); end
    endtask

    task automatic test_abort();
        logic [7:0] partial = 8'b1101_1000;
        logic [7:0] s;
        logic       b;
        int         p0 = rx_pulses;
        cs_begin();
        for (int i = 7; i >= 3; i--) begin
            spi_bit(partial[i], b);
            if (i == 6) tx_write(8'h66);
        end
        cs_end();
        n_vec++; if (rx_pulses - p0 != 0) begin n_err++; $display("FAIL abort_no_pulse got %0d want 0", rx_pulses - p0); end
        n_vec++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL abort_hold_kept got %b want 0", tx_ready); end
        cs_begin();
        spi_word(8'h81, s);
        cs_end();
        n_vec++; if (rx_pulses - p0 != 1) begin n_err++; $display("FAIL abort_one_pulse got %0d want 1", rx_pulses - p0); end
        n_vec++; if (rx_last !== 8'h81) begin n_err++; $display("FAIL abort_rx_data got %h want 81", rx_last); end
        n_vec++; if (s !== 8'h66) begin n_err++; $display("FAIL abort_miso got %h want 66", s); end
    endtask

    task automatic test_reset_midword();
        logic [7:0] s;
        logic       b;
        int         p0;
        tx_write(8'h99);
        cs_begin();
        spi_bit(1'b1, b);
        tx_write(8'h42);
        spi_bit(1'b0, b);
        spi_bit(1'b1, b);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rstmid_rx_data got %h want 00", rx_data); end
        n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_rx_valid got %b want 0", rx_valid); end
        n_vec++; if (spi_miso_oe !== 1'b0) begin n_err++; $display("FAIL rstmid_oe got %b want 0", spi_miso_oe); end
        n_vec++; if (spi_miso !== 1'b0) begin n_err++; $display("FAIL rstmid_miso got %b want 0", spi_miso); end
        n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_tx_ready got %b want 1", tx_ready); end
        n_vec++; if (tx_underrun !== 1'b0) begin n_err++; $display("FAIL rstmid_underrun got %b want 0", tx_underrun); end
        spi_cs = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        p0 = rx_pulses;
        tx_write(8'h24);
        cs_begin();
        spi_word(8'hE7, s);
        cs_end();
        n_vec++; if (rx_last !== 8'hE7) begin n_err++; $display("FAIL rstmid_rx_after got %h want e7", rx_last); end
        n_vec++; if (rx_pulses - p0 != 1) begin n_err++; $display("FAIL rstmid_pulses got %0d want 1", rx_pulses - p0); end
        n_vec++; if (s !== 8'h24) begin n_err++; $display("FAIL rstmid_miso_after got %h want 24", s); end
    endtask

    initial begin
        @(negedge sys_clk);
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_reset_midword();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
